// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war game blocks.
//   cpu_state_t : state encoding of the computer opponent (cpu_player)
//   LFSR_W      : width of the game's pseudo-random LFSR, used as the
//                 default data width of the blocks that consume its state
package tug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SAMPLE,
        PRESS,
        COOL
    } cpu_state_t;

    localparam int LFSR_W = 9;

endpackage

// File: rtl/cpu_player.sv
// Computer opponent for the tug-of-war game.
// At a fixed rate it steps the external LFSR and compares the LFSR state
// against the difficulty threshold. A hit produces a one-cycle press
// pulse, followed by a cooldown before sampling resumes.
//
// Ports:
//   clk          : system clock, rising-edge active
//   reset_n      : synchronous active-low reset
//   enable       : game running; low returns the block to IDLE
//   difficulty   : unsigned threshold, higher means more frequent presses
//   lfsr_state   : current LFSR state
//   lfsr_advance : one-cycle pulse to the LFSR enable
//   press        : one-cycle computer button press
//   busy         : high in every state except IDLE
module cpu_player
    import tug_pkg::*;
#(
    parameter int WIDTH         = LFSR_W,
    parameter int SAMPLE_PERIOD = 8,
    parameter int COOLDOWN      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] difficulty,
    input  logic [WIDTH-1:0] lfsr_state,
    output logic             lfsr_advance,
    output logic             press,
    output logic             busy
);

    // One counter serves both the WAIT and COOL intervals, so it has to
    // hold the larger of the two terminal counts.
    localparam int CNT_MAX = (SAMPLE_PERIOD > COOLDOWN) ? SAMPLE_PERIOD : COOLDOWN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN - 1);

    cpu_state_t       state;
    cpu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             hit;

    // The compare uses the state held during SAMPLE; the LFSR only moves
    // on the edge that ends SAMPLE.
    assign hit = (lfsr_state < difficulty);

    // State register and interval counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. Dropping enable from any state goes straight to
    // IDLE, so re-enabling always begins with a full WAIT interval.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = WAIT;
                WAIT:    if (cnt == WAIT_LAST) state_next = SAMPLE;
                SAMPLE:  state_next = hit ? PRESS : WAIT;
                PRESS:   state_next = COOL;
                COOL:    if (cnt == COOL_LAST) state_next = WAIT;
                default: state_next = IDLE;
            endcase
        end
    end

    // The counter restarts from zero on every state change and only
    // counts while dwelling in WAIT or COOL.
    always_comb begin
        cnt_next = '0;
        if ((state_next == state) && ((state == WAIT) || (state == COOL))) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Moore outputs, gated by enable so that a disable takes effect in
    // the same cycle rather than one cycle later.
    always_comb begin
        lfsr_advance = (state == SAMPLE) && enable;
        press        = (state == PRESS) && enable;
        busy         = (state != IDLE);
    end

endmodule
